// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: display codes,
// active-low segment patterns and the frame-buffer entry layout.
package ssd_pkg;

   localparam logic [4:0] SSD_DASH  = 5'h0D;
   localparam logic [4:0] SSD_R     = 5'h0E;
   localparam logic [4:0] SSD_N     = 5'h0F;
   localparam logic [4:0] SSD_E     = 5'h10;
   localparam logic [4:0] SSD_F     = 5'h11;
   localparam logic [4:0] SSD_P     = 5'h12;
   localparam logic [4:0] SSD_BLANK = 5'h1F;

   localparam logic [7:0] SEG_OFF   = 8'hFF;

   // {dp,g,f,e,d,c,b,a}, active-low, dp bit held high
   localparam logic [7:0] PAT_0     = 8'hC0;
   localparam logic [7:0] PAT_1     = 8'hF9;
   localparam logic [7:0] PAT_2     = 8'hA4;
   localparam logic [7:0] PAT_3     = 8'hB0;
   localparam logic [7:0] PAT_4     = 8'h99;
   localparam logic [7:0] PAT_5     = 8'h92;
   localparam logic [7:0] PAT_6     = 8'h82;
   localparam logic [7:0] PAT_7     = 8'hF8;
   localparam logic [7:0] PAT_8     = 8'h80;
   localparam logic [7:0] PAT_9     = 8'h90;
   localparam logic [7:0] PAT_A     = 8'h88;
   localparam logic [7:0] PAT_B     = 8'h83;
   localparam logic [7:0] PAT_C     = 8'hC6;
   localparam logic [7:0] PAT_DASH  = 8'hBF;
   localparam logic [7:0] PAT_R     = 8'hAF;
   localparam logic [7:0] PAT_N     = 8'hAB;
   localparam logic [7:0] PAT_E     = 8'h86;
   localparam logic [7:0] PAT_F     = 8'h8E;
   localparam logic [7:0] PAT_P     = 8'h8C;

   typedef struct packed {
      logic [4:0] code;
      logic       dp;
   } ssd_entry_t;

   localparam ssd_entry_t ENTRY_RESET = '{code: SSD_BLANK, dp: 1'b0};

   function automatic logic [7:0] seg_pattern(input logic [4:0] code);
      logic [7:0] pat;
      case (code)
         5'h00:     pat = PAT_0;
         5'h01:     pat = PAT_1;
         5'h02:     pat = PAT_2;
         5'h03:     pat = PAT_3;
         5'h04:     pat = PAT_4;
         5'h05:     pat = PAT_5;
         5'h06:     pat = PAT_6;
         5'h07:     pat = PAT_7;
         5'h08:     pat = PAT_8;
         5'h09:     pat = PAT_9;
         5'h0A:     pat = PAT_A;
         5'h0B:     pat = PAT_B;
         5'h0C:     pat = PAT_C;
         SSD_DASH:  pat = PAT_DASH;
         SSD_R:     pat = PAT_R;
         SSD_N:     pat = PAT_N;
         SSD_E:     pat = PAT_E;
         SSD_F:     pat = PAT_F;
         SSD_P:     pat = PAT_P;
         default:   pat = SEG_OFF;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Frame-buffer write port and display controls between the UI logic and
// the scan driver.
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int AW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [4:0]            wr_code;
   logic                  wr_dp;
   logic [NUM_DIGITS-1:0] blink_mask;
   logic                  lz_en;

   modport master (
      output wr_en, wr_addr, wr_code, wr_dp, blink_mask, lz_en
   );

   modport slave (
      input wr_en, wr_addr, wr_code, wr_dp, blink_mask, lz_en
   );
endinterface

// File: rtl/ssd_decode.sv
// Combinational display-code to active-low seven-segment decoder
// (decimal point excluded).
module ssd_decode
   import ssd_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] seg
);
   logic [7:0] pat;

   always_comb begin
      pat = seg_pattern(code);
      seg = pat[6:0];
   end
endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame buffer,
// per-digit blink, leading-zero suppression and inter-digit blanking.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   ssd_scan_driver_if.slave      bus,
   output logic [NUM_DIGITS-1:0] an,
   output logic [7:0]            seg
);
   localparam int AW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   ssd_entry_t            entry_reg [NUM_DIGITS];
   logic [PRE_W-1:0]      pre_reg;
   logic [AW-1:0]         idx_reg;
   logic [FRM_W-1:0]      frame_reg;
   logic                  bon_reg;
   logic [NUM_DIGITS-1:0] an_reg;
   logic [7:0]            seg_reg;

   logic                  pre_last;
   logic                  idx_last;
   logic                  frame_last;
   logic                  blank_now;
   logic [NUM_DIGITS-1:0] entry_zero;
   logic [NUM_DIGITS-1:0] lz_tail;
   logic [NUM_DIGITS-1:0] suppress;
   ssd_entry_t            cur_entry;
   logic                  cur_supp;
   logic [6:0]            cur_pat;

   assign pre_last   = (pre_reg == PRE_W'(REFRESH_DIV - 1));
   assign idx_last   = (idx_reg == AW'(NUM_DIGITS - 1));
   assign frame_last = (frame_reg == FRM_W'(BLINK_FRAMES - 1));
   assign blank_now  = (32'(pre_reg) < BLANK_CYCLES);

   // Out-of-range addresses match no entry and are dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) entry_reg[i] <= ENTRY_RESET;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.wr_en && (bus.wr_addr == AW'(i)))
               entry_reg[i] <= '{code: bus.wr_code, dp: bus.wr_dp};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_reg   <= '0;
         idx_reg   <= '0;
         frame_reg <= '0;
         bon_reg   <= 1'b1;
      end else begin
         pre_reg <= pre_last ? '0 : pre_reg + PRE_W'(1);
         if (pre_last) begin
            idx_reg <= idx_last ? '0 : idx_reg + AW'(1);
            if (idx_last) begin
               frame_reg <= frame_last ? '0 : frame_reg + FRM_W'(1);
               if (frame_last) bon_reg <= ~bon_reg;
            end
         end
      end
   end

   // A digit is a leading zero when it and every more-significant entry are blank-zero
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_supp
         assign entry_zero[gi] = (entry_reg[gi].code == 5'd0) && !entry_reg[gi].dp;
         assign lz_tail[gi]    = &entry_zero[NUM_DIGITS-1:gi];
         if (gi == 0) begin : g_lsd
            assign suppress[gi] = bus.blink_mask[gi] & ~bon_reg;
         end else begin : g_msd
            assign suppress[gi] = (bus.blink_mask[gi] & ~bon_reg) |
                                  (bus.lz_en & lz_tail[gi]);
         end
      end
   endgenerate

   always_comb begin
      cur_entry = entry_reg[0];
      cur_supp  = suppress[0];
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (idx_reg == AW'(i)) begin
            cur_entry = entry_reg[i];
            cur_supp  = suppress[i];
         end
      end
   end

   ssd_decode u_decode (
      .code (cur_entry.code),
      .seg  (cur_pat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_reg  <= '1;
         seg_reg <= SEG_OFF;
      end else if (blank_now) begin
         an_reg  <= '1;
         seg_reg <= SEG_OFF;
      end else begin
         an_reg  <= ~(NUM_DIGITS'(1) << idx_reg);
         seg_reg <= cur_supp ? SEG_OFF : {~cur_entry.dp, cur_pat};
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed and randomized checks of the scan driver against a time-indexed
// reference model of the display.
module tb_ssd_scan_driver;
   localparam int ND    = 4;
   localparam int RD    = 8;
   localparam int BK    = 2;
   localparam int BF    = 2;
   localparam int FRAME = RD * ND;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] an;
   logic [7:0] seg;

   ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   ssd_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BK),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .an    (an),
      .seg   (seg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: display state is a pure function of cycles since reset
   int         t;
   logic [4:0] mcode [ND];
   logic       mdp   [ND];
   logic [3:0] exp_an;
   logic [7:0] exp_seg;

   function automatic logic [7:0] ref_pat(input logic [4:0] c);
      case (c)
         5'h00: return 8'hC0;  5'h01: return 8'hF9;  5'h02: return 8'hA4;
         5'h03: return 8'hB0;  5'h04: return 8'h99;  5'h05: return 8'h92;
         5'h06: return 8'h82;  5'h07: return 8'hF8;  5'h08: return 8'h80;
         5'h09: return 8'h90;  5'h0A: return 8'h88;  5'h0B: return 8'h83;
         5'h0C: return 8'hC6;  5'h0D: return 8'hBF;  5'h0E: return 8'hAF;
         5'h0F: return 8'hAB;  5'h10: return 8'h86;  5'h11: return 8'h8E;
         5'h12: return 8'h8C;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [11:0] ref_out(input int tt);
      int         pre_m;
      int         idx_m;
      bit         bon_m;
      bit         zero_tail;
      bit         supp;
      logic [7:0] p;
      logic [3:0] a;
      pre_m = tt % RD;
      idx_m = (tt / RD) % ND;
      bon_m = (((tt / FRAME) / BF) % 2) == 0;
      if (pre_m < BK) return {4'hF, 8'hFF};
      zero_tail = 1'b1;
      for (int j = idx_m; j < ND; j++)
         if (mcode[j] != 5'd0 || mdp[j]) zero_tail = 1'b0;
      supp = (bus.blink_mask[idx_m] && !bon_m) || (bus.lz_en && idx_m != 0 && zero_tail);
      a = ~(4'b0001 << idx_m);
      p = ref_pat(mcode[idx_m]);
      if (supp) return {a, 8'hFF};
      return {a, ~mdp[idx_m], p[6:0]};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         t <= 0;
         for (int j = 0; j < ND; j++) begin
            mcode[j] <= 5'h1F;
            mdp[j]   <= 1'b0;
         end
         exp_an  <= 4'hF;
         exp_seg <= 8'hFF;
      end else begin
         {exp_an, exp_seg} <= ref_out(t);
         if (bus.wr_en && int'(bus.wr_addr) < ND) begin
            mcode[bus.wr_addr] <= bus.wr_code;
            mdp[bus.wr_addr]   <= bus.wr_dp;
         end
         t <= t + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      check("scan", {20'd0, an, seg}, {20'd0, exp_an, exp_seg});
   endtask

   task automatic wr(input int addr, input logic [4:0] code, input logic dp);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(addr);
      bus.wr_code = code;
      bus.wr_dp   = dp;
      cyc();
      bus.wr_en   = 1'b0;
   endtask

   // Advance until the next edge will sample slot d at prescaler value p
   task automatic wait_slot(input int d, input int p);
      int guard = 0;
      while ((t % FRAME) != d * RD + p && guard < 200) begin
         cyc();
         guard++;
      end
      check("wait_slot", 32'(guard < 200), 32'd1);
   endtask

   task automatic show(input int d, input logic [3:0] ean, input logic [7:0] eseg, input string tag);
      wait_slot(d, 4);
      cyc();
      check({tag, "_an"}, 32'(an), 32'(ean));
      check({tag, "_seg"}, 32'(seg), 32'(eseg));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tt;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_code    = '0;
      bus.wr_dp      = 1'b0;
      bus.blink_mask = '0;
      bus.lz_en      = 1'b0;

      // Reset held, then idle walk over a blank buffer
      repeat (2) @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'hFF);
      reset = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         cyc();
         case (n)
            1:  check("walk1_an", 32'(an), 32'hF);
            3:  check("walk3_an", 32'(an), 32'hE);
            9:  check("walk9_an", 32'(an), 32'hF);
            11: check("walk11_an", 32'(an), 32'hD);
            19: check("walk19_an", 32'(an), 32'hB);
            27: check("walk27_an", 32'(an), 32'h7);
            28: check("walk28_seg", 32'(seg), 32'hFF);
            default: ;
         endcase
      end

      // Digits 1..4 with decimal point on digit 1
      wr(0, 5'd1, 1'b0);
      wr(1, 5'd2, 1'b1);
      wr(2, 5'd3, 1'b0);
      wr(3, 5'd4, 1'b0);
      show(0, 4'hE, 8'hF9, "d0");
      show(1, 4'hD, 8'h24, "d1dp");
      show(2, 4'hB, 8'hB0, "d2");
      show(3, 4'h7, 8'h99, "d3");

      // Write to the digit being displayed
      wait_slot(0, 5);
      wr(0, 5'h0D, 1'b0);
      cyc();
      check("live_wr_seg", 32'(seg), 32'hBF);

      // Leading-zero suppression
      wr(3, 5'd0, 1'b0);
      wr(2, 5'd0, 1'b0);
      wr(1, 5'd0, 1'b0);
      wr(0, 5'd7, 1'b0);
      bus.lz_en = 1'b1;
      show(3, 4'h7, 8'hFF, "lz3");
      show(2, 4'hB, 8'hFF, "lz2");
      show(1, 4'hD, 8'hFF, "lz1");
      show(0, 4'hE, 8'hF8, "lz0");
      bus.lz_en = 1'b0;
      show(3, 4'h7, 8'hC0, "nolz3");
      show(1, 4'hD, 8'hC0, "nolz1");

      // Blink on digit 0 only
      wr(0, 5'd8, 1'b0);
      bus.blink_mask = 4'b0001;
      for (int f = 0; f < 6; f++) begin
         wait_slot(0, 4);
         tt = t;
         cyc();
         check("blink_d0", 32'(seg), (((tt / FRAME) / BF) % 2 == 0) ? 32'h80 : 32'hFF);
         show(1, 4'hD, 8'hC0, "blink_d1");
      end
      bus.blink_mask = '0;

      // Asynchronous reset mid-slot
      wait_slot(2, 4);
      cyc();
      check("pre_rst_an", 32'(an), 32'hB);
      #2 reset = 1'b1;
      #1;
      check("async_rst_an", 32'(an), 32'hF);
      check("async_rst_seg", 32'(seg), 32'hFF);
      @(negedge clk);
      reset = 1'b0;
      cyc();
      check("post_rst_blank", 32'(an), 32'hF);
      show(0, 4'hE, 8'hFF, "post_rst_d0");
      show(3, 4'h7, 8'hFF, "post_rst_d3");

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_addr = 2'($urandom_range(0, 3));
         bus.wr_code = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         bus.wr_dp   = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) bus.blink_mask = 4'($urandom);
         if ($urandom_range(0, 49) == 0) bus.lz_en = 1'($urandom_range(0, 1));
         cyc();
      end
      bus.wr_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
